euler1_result_reader: RTL and testbench

Host-side reader for the Euler-1 accumulator tile's 8-bit io interface. It resets the tile, waits for `valid` with a cycle timeout, then walks `mux_sel` through the slices. Each 6-bit slice is captured and assembled into the full result. It sits between the tile's io pins and on-chip or board test logic, replacing manual mux-sel stepping.

---
 rtl/euler1_result_reader.sv | 176 +++++++++++++++++
 tb/tb_euler1_result_reader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/euler1_result_reader.sv
// Host-side reader for the Euler-1 accumulator tile: resets the tile, waits for valid, then steps mux_sel and assembles the slices.
// Optional macro READER_RETRY_EN: the first valid timeout in a run triggers one extra tile reset and wait before giving up.
module euler1_result_reader #(
  parameter int SLICE_W    = 6,
  parameter int NUM_SLICES = 3,
  parameter int TIMEOUT    = 600,
  parameter int SETTLE     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          dut_rst,
  output logic                          dut_write_en,
  output logic [1:0]                    dut_mux_sel,
  input  logic                          dut_valid,
  input  logic [SLICE_W-1:0]            dut_result,
  output logic [SLICE_W*NUM_SLICES-1:0] result,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout
);

  localparam int RES_W = SLICE_W * NUM_SLICES;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [1:0]       SLICE_LAST  = 2'(NUM_SLICES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PULSE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEL   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  generate
    if (NUM_SLICES < 1 || NUM_SLICES > 4) begin : g_bad_slices
      $error("NUM_SLICES must be 1..4 because mux_sel is 2 bits");
    end
    if (SETTLE < 1) begin : g_bad_settle
      $error("SETTLE must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("TIMEOUT must be at least 1");
    end
  endgenerate

  logic [2:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [SET_W-1:0] settle_cnt;
`ifdef READER_RETRY_EN
  logic             retry_used;
`endif

  // Replace slice idx of the accumulated value with a freshly captured slice.
  function automatic logic [RES_W-1:0] insert_slice(input logic [RES_W-1:0]   acc,
                                                    input logic [1:0]         idx,
                                                    input logic [SLICE_W-1:0] s);
    logic [RES_W-1:0] r;
    r = acc;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (idx == 2'(i)) r[i*SLICE_W +: SLICE_W] = s;
    end
    return r;
  endfunction

  // The tile is read-only from here; its write port is never exercised.
  assign dut_write_en = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      settle_cnt  <= '0;
      dut_rst     <= 1'b0;
      dut_mux_sel <= 2'd0;
      result      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
`ifdef READER_RETRY_EN
      retry_used  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_PULSE;
            dut_rst <= 1'b1;
            busy    <= 1'b1;
            result  <= '0;
`ifdef READER_RETRY_EN
            retry_used <= 1'b0;
`endif
          end
        end

        S_PULSE: begin
          dut_rst  <= 1'b0;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          // A valid seen on the same edge the budget runs out still wins.
          if (dut_valid) begin
            dut_mux_sel <= 2'd0;
            settle_cnt  <= '0;
            state       <= S_SEL;
          end else if (wait_cnt == WAIT_LAST) begin
`ifdef READER_RETRY_EN
            if (!retry_used) begin
              retry_used <= 1'b1;
              dut_rst    <= 1'b1;
              state      <= S_PULSE;
            end else begin
              timeout <= 1'b1;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= S_DONE;
            end
`else
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
`endif
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        S_SEL: begin
          if (settle_cnt == SETTLE_LAST) begin
            result     <= insert_slice(result, dut_mux_sel, dut_result);
            settle_cnt <= '0;
            if (dut_mux_sel == SLICE_LAST) begin
              dut_mux_sel <= 2'd0;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= S_DONE;
            end else begin
              dut_mux_sel <= dut_mux_sel + 2'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end

        S_DONE: begin
          dut_mux_sel <= 2'd0;
          if (start) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            result  <= '0;
            dut_rst <= 1'b1;
            busy    <= 1'b1;
            state   <= S_PULSE;
`ifdef READER_RETRY_EN
            retry_used <= 1'b0;
`endif
          end
        end

        default: begin
          state       <= S_IDLE;
          dut_rst     <= 1'b0;
          dut_mux_sel <= 2'd0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_euler1_result_reader.sv
// Directed bench for euler1_result_reader: behavioural tile models drive valid/slices, hand-computed expectations.
module tb_euler1_result_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b;
  logic        dut_rst_a, we_a, valid_a, busy_a, done_a, timeout_a;
  logic [1:0]  mux_a;
  logic [5:0]  slice_a;
  logic [17:0] result_a;
  logic        dut_rst_b, we_b, valid_b, busy_b, done_b, timeout_b;
  logic [1:0]  mux_b;
  logic [5:0]  slice_b;
  logic [17:0] result_b;

  euler1_result_reader u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_rst(dut_rst_a), .dut_write_en(we_a),
    .dut_mux_sel(mux_a), .dut_valid(valid_a), .dut_result(slice_a), .result(result_a),
    .busy(busy_a), .done(done_a), .timeout(timeout_a)
  );

  euler1_result_reader #(.SETTLE(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_rst(dut_rst_b), .dut_write_en(we_b),
    .dut_mux_sel(mux_b), .dut_valid(valid_b), .dut_result(slice_b), .result(result_b),
    .busy(busy_b), .done(done_b), .timeout(timeout_b)
  );

  // Tile model A: valid rises t_delay edges after the t_need-th reset pulse
  logic       t_clear = 1'b1;
  int         t_delay = 500;
  int         t_need  = 1;
  int         t_cnt   = 0;
  int         t_seen  = 0;
  logic [5:0] t_sl0, t_sl1, t_sl2;

  always @(posedge clk) begin
    if (t_clear) begin
      t_cnt  <= 0;
      t_seen <= 0;
    end else if (dut_rst_a) begin
      t_cnt  <= 0;
      t_seen <= t_seen + 1;
    end else if (t_cnt < 100000) begin
      t_cnt <= t_cnt + 1;
    end
  end

  assign valid_a = (t_seen >= t_need) && (t_cnt >= t_delay) && !dut_rst_a;

  always_comb begin
    case (mux_a)
      2'd0:    slice_a = t_sl0;
      2'd1:    slice_a = t_sl1;
      2'd2:    slice_a = t_sl2;
      default: slice_a = 6'h3f;
    endcase
  end

  // Tile model B: fixed 20-edge delay, fixed slices 16/59/56
  int tb_cnt  = 0;
  int tb_seen = 0;
  always @(posedge clk) begin
    if (dut_rst_b) begin
      tb_cnt  <= 0;
      tb_seen <= tb_seen + 1;
    end else if (tb_cnt < 100000) begin
      tb_cnt <= tb_cnt + 1;
    end
  end
  assign valid_b = (tb_seen > 0) && (tb_cnt >= 20) && !dut_rst_b;

  always_comb begin
    case (mux_b)
      2'd0:    slice_b = 6'd16;
      2'd1:    slice_b = 6'd59;
      2'd2:    slice_b = 6'd56;
      default: slice_b = 6'h3f;
    endcase
  end

  // Event monitor for instance A, stamped with the posedge count
  int         edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic       prev_rst = 1'b0, prev_valid = 1'b0, prev_done = 1'b0;
  logic [1:0] prev_mux = 2'd0;
  int         rst_pulses = 0, last_rst_edge = 0, prev_rst_edge = 0;
  int         cur_w = 0, last_w = 0, valid_edge = 0, done_edge = 0;
  logic [5:0] mux_hist = 6'd0;

  always @(negedge clk) begin
    prev_rst   <= dut_rst_a;
    prev_valid <= valid_a;
    prev_done  <= done_a;
    prev_mux   <= mux_a;
    if (dut_rst_a && !prev_rst) begin
      rst_pulses    <= rst_pulses + 1;
      prev_rst_edge <= last_rst_edge;
      last_rst_edge <= edge_cnt;
      cur_w         <= 1;
    end else if (dut_rst_a) begin
      cur_w <= cur_w + 1;
    end
    if (!dut_rst_a && prev_rst) last_w <= cur_w;
    // valid seen now is sampled by the DUT at the next edge
    if (valid_a && !prev_valid) valid_edge <= edge_cnt + 1;
    if (done_a && !prev_done) done_edge <= edge_cnt;
    if (mux_a != prev_mux) mux_hist <= {mux_hist[3:0], mux_a};
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int n;
    n = 0;
    while (!done_a && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  task automatic clear_tile_a();
    t_clear = 1'b1;
    tick(1);
    t_clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n, vb, db;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    t_sl0 = 6'd16; t_sl1 = 6'd59; t_sl2 = 6'd56;
    tick(3);
    check("rst_result", result_a, 0);
    check("rst_done", done_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_timeout", timeout_a, 0);
    check("rst_mux", mux_a, 0);
    check("rst_dut_rst", dut_rst_a, 0);
    check("rst_we", we_a, 0);
    check("rst_we_b", we_b, 0);
    check("rst_done_b", done_b, 0);
    rst = 1'b0; t_clear = 1'b0;
    tick(2);

    // Normal read, with a stray start while waiting for valid
    p0 = rst_pulses;
    pulse_start_a();
    check("start_dut_rst", dut_rst_a, 1);
    check("start_busy", busy_a, 1);
    tick(50);
    pulse_start_a();
    wait_done_a(1000);
    check("norm_done", done_a, 1);
    check("norm_result", result_a, 233168);
    check("norm_timeout", timeout_a, 0);
    check("norm_busy", busy_a, 0);
    check("norm_mux", mux_a, 0);
    check("norm_pulses", rst_pulses - p0, 1);
    check("norm_pulse_width", last_w, 1);
    check("norm_latency", done_edge - valid_edge, 3);
    check("norm_mux_seq", mux_hist, 6'b01_10_00);
    tick(5);
    check("done_sticky", done_a, 1);
    check("result_held", result_a, 233168);

    // Start in DONE restarts; new slices 5/10/63 -> 5 + 10*64 + 63*4096
    t_sl0 = 6'd5; t_sl1 = 6'd10; t_sl2 = 6'd63;
    p0 = rst_pulses;
    pulse_start_a();
    check("restart_done_clr", done_a, 0);
    check("restart_dut_rst", dut_rst_a, 1);
    check("restart_result_clr", result_a, 0);
    check("restart_busy", busy_a, 1);
    wait_done_a(1000);
    check("restart_done", done_a, 1);
    check("restart_result", result_a, 258693);
    check("restart_pulses", rst_pulses - p0, 1);
    t_sl0 = 6'd16; t_sl1 = 6'd59; t_sl2 = 6'd56;

`ifdef READER_RETRY_EN
    // Tile ignores the first reset; valid 100 edges after the second
    clear_tile_a();
    t_delay = 100; t_need = 2;
    p0 = rst_pulses;
    pulse_start_a();
    wait_done_a(2000);
    check("retry_done", done_a, 1);
    check("retry_pulses", rst_pulses - p0, 2);
    check("retry_spacing", last_rst_edge - prev_rst_edge, 601);
    check("retry_result", result_a, 233168);
    check("retry_timeout", timeout_a, 0);
`else
    // Valid never arrives
    clear_tile_a();
    t_need = 99;
    p0 = rst_pulses;
    pulse_start_a();
    wait_done_a(1000);
    check("to_done", done_a, 1);
    check("to_timeout", timeout_a, 1);
    check("to_result", result_a, 0);
    check("to_delay", done_edge - last_rst_edge, 601);
    check("to_pulses", rst_pulses - p0, 1);
`endif

    // Valid one edge too late still times out
    clear_tile_a();
    t_need = 1; t_delay = 600;
    pulse_start_a();
    wait_done_a(2000);
    check("late_done", done_a, 1);
    check("late_timeout", timeout_a, 1);
    check("late_result", result_a, 0);

    // Valid on the same edge the counter reaches TIMEOUT: valid wins
    clear_tile_a();
    t_delay = 599;
    pulse_start_a();
    wait_done_a(2000);
    check("coll_valid_edge", valid_edge - last_rst_edge, 601);
    check("coll_timeout", timeout_a, 0);
    check("coll_result", result_a, 233168);
    check("coll_latency", done_edge - valid_edge, 3);

    // Reset while mux_sel=1 with slice 0 already captured
    t_delay = 500;
    pulse_start_a();
    n = 0;
    while (mux_a != 2'd1 && n < 1000) begin
      tick(1);
      n++;
    end
    check("mid_mux1", mux_a, 1);
    check("mid_slice0", result_a, 16);
    rst = 1'b1;
    tick(1);
    check("mid_rst_result", result_a, 0);
    check("mid_rst_done", done_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_mux", mux_a, 0);
    rst = 1'b0;
    tick(1);
    pulse_start_a();
    wait_done_a(1000);
    check("mid_rerun_done", done_a, 1);
    check("mid_rerun_result", result_a, 233168);

    // SETTLE=2 instance: done 6 edges after valid is sampled
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    vb = -1;
    n = 0;
    while (!done_b && n < 200) begin
      if (valid_b && vb < 0) vb = edge_cnt + 1;
      tick(1);
      n++;
    end
    db = edge_cnt;
    check("s2_done", done_b, 1);
    check("s2_latency", db - vb, 6);
    check("s2_result", result_b, 233168);
    check("s2_timeout", timeout_b, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
